// File: rtl/md_unit_32.sv
// md_unit_32: multi-cycle multiply/divide unit with architectural HI/LO.
// Executes mult/multu/div/divu in 34 cycles; mthi/mtlo update HI/LO at once.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   md_a         rs operand (dividend / multiplicand / mthi-mtlo source)
//   md_b         rt operand (divisor / multiplier)
//   md_op        000 none, 001 mult, 010 multu, 011 div, 100 divu,
//                101 mthi, 110 mtlo, 111 none
//   start        request qualifier, sampled only while idle
//   busy         operation in flight; pipeline holds md/mfhi/mflo
//   done         one-cycle pulse, HI/LO valid in the same cycle
//   div_by_zero  qualified by done; finished divide had md_b = 0
//   hi, lo       HI and LO registers
//
// Build option: define MD_DIV_EN to include the divide datapath.
// Without it div/divu are treated as no-ops and div_by_zero is tied 0.

module md_unit_32 #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] md_a,
    input  logic [XLEN-1:0] md_b,
    input  logic [2:0]      md_op,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            div_by_zero,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t state, state_n;

    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd;
    logic [4:0]        cnt;
    logic              q_neg;

    logic              is_mul;
    logic              is_mthi;
    logic              is_mtlo;
    logic              go_calc;
    logic              sgn_op;
    logic              neg_a;
    logic              neg_b;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;

    logic [XLEN:0]     add_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [2*XLEN-1:0] prod;

`ifdef MD_DIV_EN
    localparam logic [2:0] OP_DIVU = 3'b100;

    logic              is_div;
    logic              op_div;
    logic              r_neg;
    logic              dz;
    logic [XLEN:0]     trial;
    logic              trial_ge;
    logic [XLEN-1:0]   rem_sub;
    logic [2*XLEN-1:0] div_next;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
`endif

    // ---------------- decode ----------------
    assign is_mul  = (md_op == OP_MULT) || (md_op == OP_MULTU);
    assign is_mthi = (md_op == OP_MTHI);
    assign is_mtlo = (md_op == OP_MTLO);
    assign sgn_op  = (md_op == OP_MULT) || (md_op == OP_DIV);

`ifdef MD_DIV_EN
    assign is_div  = (md_op == OP_DIV) || (md_op == OP_DIVU);
    assign go_calc = is_mul || is_div;
`else
    assign go_calc = is_mul;
`endif

    assign neg_a = sgn_op && md_a[XLEN-1];
    assign neg_b = sgn_op && md_b[XLEN-1];
    assign mag_a = neg_a ? -md_a : md_a;
    assign mag_b = neg_b ? -md_b : md_b;

    assign busy = (state != S_IDLE);

    // ---------------- multiply step ----------------
    // acc = {partial product, remaining multiplier bits}; the carry of the
    // upper add becomes bit 63 after the right shift.
    assign add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
    assign mul_next = acc[0] ? {add_sum, acc[XLEN-1:1]}
                             : {1'b0, acc[2*XLEN-1:1]};
    assign prod     = q_neg ? -acc : acc;

`ifdef MD_DIV_EN
    // ---------------- divide step ----------------
    // acc = {partial remainder, dividend bits / quotient bits}.
    // When trial >= divisor the difference fits in XLEN bits, so a
    // narrow subtract is enough.
    assign trial    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign trial_ge = (trial >= {1'b0, opnd});
    assign rem_sub  = trial[XLEN-1:0] - opnd;
    assign div_next = trial_ge ? {rem_sub, acc[XLEN-2:0], 1'b1}
                               : {trial[XLEN-1:0], acc[XLEN-2:0], 1'b0};

    // With a zero divisor the remainder ends as |a|; re-applying a's
    // sign restores the original md_a for HI.
    assign quo     = acc[XLEN-1:0];
    assign rem     = acc[2*XLEN-1:XLEN];
    assign quo_fix = dz ? {XLEN{1'b1}} : (q_neg ? -quo : quo);
    assign rem_fix = r_neg ? -rem : rem;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            S_IDLE: if (start && go_calc) state_n = S_CALC;
            S_CALC: if (cnt == 5'd31) state_n = S_FIX;
            S_FIX:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
            acc    <= '0;
            opnd   <= '0;
            cnt    <= '0;
            q_neg  <= 1'b0;
`ifdef MD_DIV_EN
            op_div      <= 1'b0;
            r_neg       <= 1'b0;
            dz          <= 1'b0;
            div_by_zero <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef MD_DIV_EN
            div_by_zero <= 1'b0;
`endif
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        unique case (1'b1)
                            is_mul: begin
                                acc   <= {{XLEN{1'b0}}, mag_b};
                                opnd  <= mag_a;
                                cnt   <= '0;
                                q_neg <= neg_a ^ neg_b;
`ifdef MD_DIV_EN
                                op_div <= 1'b0;
                                r_neg  <= 1'b0;
                                dz     <= 1'b0;
`endif
                            end
`ifdef MD_DIV_EN
                            is_div: begin
                                acc    <= {{XLEN{1'b0}}, mag_a};
                                opnd   <= mag_b;
                                cnt    <= '0;
                                q_neg  <= neg_a ^ neg_b;
                                op_div <= 1'b1;
                                r_neg  <= neg_a;
                                dz     <= (md_b == '0);
                            end
`endif
                            is_mthi: hi <= md_a;
                            is_mtlo: lo <= md_a;
                            default: ;
                        endcase
                    end
                end
                S_CALC: begin
                    cnt <= cnt + 5'd1;
`ifdef MD_DIV_EN
                    acc <= op_div ? div_next : mul_next;
`else
                    acc <= mul_next;
`endif
                end
                S_FIX: begin
                    done <= 1'b1;
`ifdef MD_DIV_EN
                    if (op_div) begin
                        hi          <= rem_fix;
                        lo          <= quo_fix;
                        div_by_zero <= dz;
                    end else begin
                        {hi, lo} <= prod;
                    end
`else
                    {hi, lo} <= prod;
`endif
                end
                default: ;
            endcase
        end
    end

`ifndef MD_DIV_EN
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_md_unit_32.sv
// tb_md_unit_32: directed bench for md_unit_32 with an arithmetic
// reference model compared every cycle plus literal spot checks.

module tb_md_unit_32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] md_a = 32'd0;
    logic [31:0] md_b = 32'd0;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    md_unit_32 dut (
        .clk         (clk),
        .rst         (rst),
        .md_a        (md_a),
        .md_b        (md_b),
        .md_op       (md_op),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Latency model: an accepted mult/div result appears 33 edges after
    // the sampling edge; until then the unit is busy and ignores start.
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic        m_done = 1'b0;
    logic        m_dz = 1'b0;
    int          m_left = 0;
    logic [31:0] p_hi = 32'd0;
    logic [31:0] p_lo = 32'd0;
    logic        p_dz = 1'b0;

    task automatic model_issue(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b);
        logic signed [63:0] sp;
        logic [63:0]        up;
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        p_dz = 1'b0;
        case (op)
            3'd1: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                {p_hi, p_lo} = sp;
                m_left = 33;
            end
            3'd2: begin
                up = {32'd0, a} * {32'd0, b};
                {p_hi, p_lo} = up;
                m_left = 33;
            end
`ifdef MD_DIV_EN
            3'd3: begin
                if (b == 32'd0) begin
                    p_hi = a; p_lo = 32'hFFFF_FFFF; p_dz = 1'b1;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    p_hi = 32'd0; p_lo = 32'h8000_0000;
                end else begin
                    p_lo = sa / sb;
                    p_hi = sa % sb;
                end
                m_left = 33;
            end
            3'd4: begin
                if (b == 32'd0) begin
                    p_hi = a; p_lo = 32'hFFFF_FFFF; p_dz = 1'b1;
                end else begin
                    p_lo = a / b;
                    p_hi = a % b;
                end
                m_left = 33;
            end
`endif
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
        endcase
    endtask

    always @(posedge clk) begin
        m_done = 1'b0;
        m_dz = 1'b0;
        if (rst) begin
            m_left = 0;
            m_hi = 32'd0;
            m_lo = 32'd0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_hi = p_hi;
                m_lo = p_lo;
                m_done = 1'b1;
                m_dz = p_dz;
            end
        end else if (start) begin
            model_issue(md_op, md_a, md_b);
        end
    end

    always @(negedge clk) begin
        chk("busy", {63'd0, busy}, {63'd0, m_left > 0});
        chk("done", {63'd0, done}, {63'd0, m_done});
        chk("hi", {32'd0, hi}, {32'd0, m_hi});
        chk("lo", {32'd0, lo}, {32'd0, m_lo});
        if (m_done) chk("dbz", {63'd0, div_by_zero}, {63'd0, m_dz});
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        md_op = op;
        md_a = a;
        md_b = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        md_op = 3'd0;
    endtask

    task automatic wait_done(output int cyc, output int nb);
        cyc = 1;
        nb = 0;
        while (!done && cyc < 40) begin
            if (busy) nb++;
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", {63'd0, done}, 64'd1);
    endtask

    int cyc;
    int nb;
    int ndone;
    logic [31:0] sv_hi;
    logic [31:0] sv_lo;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_hi", {32'd0, hi}, 64'd0);
        chk("rst_lo", {32'd0, lo}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        issue(3'd1, 32'hFFFF_FFFD, 32'd5);
        wait_done(cyc, nb);
        chk("mult_lat", cyc, 64'd34);
        chk("mult_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        chk("mult_lo", {32'd0, lo}, 64'hFFFF_FFF1);
        @(negedge clk);

        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(cyc, nb);
        chk("multu_busy_cycles", nb, 64'd33);
        chk("multu_hi", {32'd0, hi}, 64'hFFFF_FFFE);
        chk("multu_lo", {32'd0, lo}, 64'h1);
        @(negedge clk);

`ifdef MD_DIV_EN
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        wait_done(cyc, nb);
        chk("div_lo", {32'd0, lo}, 64'hFFFF_FFFD);
        chk("div_hi", {32'd0, hi}, 64'hFFFF_FFFF);
        chk("div_dbz", {63'd0, div_by_zero}, 64'd0);
        @(negedge clk);
        issue(3'd4, 32'd100, 32'd0);
        wait_done(cyc, nb);
        chk("divu0_hi", {32'd0, hi}, 64'h64);
        chk("divu0_lo", {32'd0, lo}, 64'hFFFF_FFFF);
        chk("divu0_dbz", {63'd0, div_by_zero}, 64'd1);
        @(negedge clk);
        issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(cyc, nb);
        chk("divovf_lo", {32'd0, lo}, 64'h8000_0000);
        chk("divovf_hi", {32'd0, hi}, 64'h0);
        chk("divovf_dbz", {63'd0, div_by_zero}, 64'd0);
        @(negedge clk);
        issue(3'd3, 32'hFFFF_FFF9, 32'd0);
        wait_done(cyc, nb);
        chk("div0s_hi", {32'd0, hi}, 64'hFFFF_FFF9);
        @(negedge clk);
`else
        sv_hi = hi;
        sv_lo = lo;
        issue(3'd3, 32'hFFFF_FFF9, 32'd2);
        chk("nodiv_busy", {63'd0, busy}, 64'd0);
        issue(3'd4, 32'd100, 32'd0);
        chk("nodivu_busy", {63'd0, busy}, 64'd0);
        repeat (3) @(negedge clk);
        chk("nodiv_hi", {32'd0, hi}, {32'd0, sv_hi});
        chk("nodiv_lo", {32'd0, lo}, {32'd0, sv_lo});
        chk("nodiv_dbz", {63'd0, div_by_zero}, 64'd0);
`endif

        issue(3'd1, 32'd7, 32'd9);
        repeat (4) @(negedge clk);
        issue(3'd6, 32'h1234, 32'd0);
        wait_done(cyc, nb);
        chk("mtlo_busy_lo", {32'd0, lo}, 64'h3F);
        chk("mtlo_busy_hi", {32'd0, hi}, 64'h0);
        @(negedge clk);
        issue(3'd6, 32'h1234, 32'd0);
        chk("mtlo_lo", {32'd0, lo}, 64'h1234);
        chk("mtlo_nodone", {63'd0, done}, 64'd0);
        issue(3'd5, 32'hCAFE_0001, 32'd0);
        chk("mthi_hi", {32'd0, hi}, 64'hCAFE_0001);

        issue(3'd1, 32'h0001_0000, 32'h0001_0000);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        start = 1'b1;
        md_op = 3'd5;
        md_a = 32'h5555_5555;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        md_op = 3'd0;
        chk("rst_mid_busy", {63'd0, busy}, 64'd0);
        chk("rst_mid_hi", {32'd0, hi}, 64'd0);
        chk("rst_mid_lo", {32'd0, lo}, 64'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("rst_no_done", ndone, 64'd0);

        issue(3'd1, 32'd3, 32'd4);
        wait_done(cyc, nb);
        chk("b2b_first_lo", {32'd0, lo}, 64'd12);
        issue(3'd2, 32'h8000_0000, 32'd2);
        wait_done(cyc, nb);
        chk("b2b_lat", cyc, 64'd34);
        chk("b2b_hi", {32'd0, hi}, 64'h1);
        chk("b2b_lo", {32'd0, lo}, 64'h0);
        issue(3'd1, 32'h8000_0000, 32'h8000_0000);
        wait_done(cyc, nb);
        chk("mult_min_hi", {32'd0, hi}, 64'h4000_0000);
        chk("mult_min_lo", {32'd0, lo}, 64'h0);
        issue(3'd1, 32'h1234_5678, 32'hFEDC_BA98);
        wait_done(cyc, nb);
        issue(3'd2, 32'hDEAD_BEEF, 32'h0000_0000);
        wait_done(cyc, nb);
        @(negedge clk);

        @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/md_unit_32.md
# md_unit_32

Multi-cycle multiply/divide unit that sits beside the single-cycle combinational ALU in the execute stage of the MiniSys-1A CPU. It takes the same two 32-bit register operands and executes mult, multu, div, divu, mthi and mtlo. Results are held in architectural HI/LO registers for mfhi/mflo. While an operation is in flight, `busy` tells the pipeline controller to stall any later multiply/divide instruction and any mfhi/mflo.

## Interface
Parameters:
- `XLEN`, 32, operand width; only 32 is supported.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  one clock; reset is synchronous and active-high.
- `md_a`  in  32  rs operand: dividend or multiplicand, or the mthi/mtlo source.
- `md_b`  in  32  rt operand: divisor or multiplier.
- `md_op`  in  3  opcode: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 none.
- `start`  in  1  request qualifier; sampled only when `busy`=0.
- `busy`  out  1  an operation is in progress.
- `done`  out  1  one-cycle pulse; HI/LO are valid in the same cycle.
- `div_by_zero`  out  1  qualified by `done`; the finished divide had `md_b`=0.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- FSM states: IDLE, CALC, FIX.
- IDLE, `start`=1 with mult/multu/div/divu:
  - latch operand magnitudes (absolute value for signed ops, raw value for unsigned ops);
  - latch result signs: quotient/product sign = sa^sb, remainder sign = sa;
  - clear the 5-bit iteration counter; go to CALC.
- IDLE, `start`=1 with mthi/mtlo: write `md_a` to HI or LO at that edge. No busy, no done.
- IDLE, `start`=1 with md_op 000/111: no effect.
- CALC runs 32 iterations, one per cycle:
  - multiply: radix-2 shift-add into a 64-bit accumulator;
  - divide: restoring shift-subtract, producing one quotient bit per cycle.
- CALC moves to FIX after the iteration with counter=31.
- FIX:
  - apply two's-complement sign correction; the product is negated as a 64-bit value;
  - write HI/LO: product {HI,LO}; for divide, HI=remainder, LO=quotient;
  - pulse `done`; return to IDLE.
- Divide by zero (`md_b`=0): HI=`md_a` (unmodified), LO=32'hFFFF_FFFF, `div_by_zero`=1 with `done`. Latency is unchanged.
- Signed overflow case 0x8000_0000 / 0xFFFF_FFFF: LO=0x8000_0000, HI=0. No flag.
- `start` while `busy`=1 is ignored, including mthi/mtlo. The pipeline must hold the instruction.
- HI/LO change only in FIX, on mthi/mtlo, or on reset.

## Timing
- Reset values: `busy`=0, `done`=0, `div_by_zero`=0, `hi`=0, `lo`=0. State is IDLE and the counter is 0.
- `start` is sampled at edge E0:
  - `busy`=1 for the cycles following E0 through E32 (33 cycles);
  - at E33, HI/LO are written, `done`=1 for exactly one cycle and `busy`=0.
- Back-to-back: a new `start` is accepted in the same cycle `done` is high (busy=0), so the next `done` comes 34 cycles later.
- mthi/mtlo: HI/LO are updated at the sampling edge, visible in the next cycle.
- `rst` mid-operation: at the next edge, return to IDLE and clear HI/LO. The aborted operation never asserts `done`.
- `rst` overrides `start` in the same cycle.

## Configuration
- `MD_DIV_EN` defined: full behaviour as above.
- `MD_DIV_EN` undefined:
  - the divide datapath is compiled out;
  - div/divu with `start` behave as md_op 000: no busy, no done, HI/LO unchanged;
  - `div_by_zero` is tied 0;
  - multiply timing is unchanged.

## Test plan
- mult, a=0xFFFF_FFFD (-3), b=5 → after 34 cycles, `done`=1, HI=0xFFFF_FFFF, LO=0xFFFF_FFF1.
- multu, a=b=0xFFFF_FFFF → HI=0xFFFF_FFFE, LO=0x0000_0001; `busy` high exactly 33 cycles.
- div, a=0xFFFF_FFF9 (-7), b=2 → LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. divu, a=100, b=0 → HI=0x64, LO=0xFFFF_FFFF, `div_by_zero`=1.
- Issue mtlo 0x1234 while busy → ignored, LO unchanged. After `done`, mtlo 0x1234 → LO=0x1234 in the next cycle, no `done`.
- Assert `rst` 10 cycles into a mult → `busy`=0, HI=LO=0 the next cycle, and no `done` within 40 cycles.
- Back-to-back: start a second mult in the `done` cycle → accepted; its `done` arrives 34 cycles later. Repeat with `MD_DIV_EN` undefined and confirm a div start yields no `busy`.
